// File: rtl/hub75_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hub75_scan_sequencer
// Description : HUB75 panel refresh sequencer. Requests one row/bitplane from
//               the external pixel shifter, blanks the panel, latches the
//               row and then lights it for a binary-weighted, brightness-
//               scaled time before moving on to the next bitplane and row.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_scan_sequencer #(
  parameter int PIXEL_HALFHEIGHT = 16,
  parameter int BITPLANES        = 6,
  parameter int BASE_TICKS       = 8,
  parameter int BLANK_TICKS      = 2,
  localparam int RW = (PIXEL_HALFHEIGHT > 1) ? $clog2(PIXEL_HALFHEIGHT) : 1,
  localparam int PW = (BITPLANES > 1) ? $clog2(BITPLANES) : 1
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    brightness,
  output logic          shift_start,
  output logic [RW-1:0] shift_row,
  output logic [PW-1:0] shift_plane,
  input  logic          shift_done,
  output logic [RW-1:0] row_address,
  output logic          row_latch,
  output logic          oe_n,
  output logic          frame_done
);

  // Product width covers (c << 8) and D * (brightness + 1) without truncation.
  localparam int PROD_W = $clog2(BASE_TICKS) + BITPLANES + 9;
  // Counter holds any DISPLAY index (< BASE_TICKS << (BITPLANES-1)) and the
  // blanking count.
  localparam int CNT_W  = PROD_W - 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_DISPLAY = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       bright_q, bright_d;
  logic             shift_start_q, shift_start_d;
  logic [RW-1:0]    shift_row_q, shift_row_d;
  logic [PW-1:0]    shift_plane_q, shift_plane_d;
  logic [RW-1:0]    row_address_q, row_address_d;
  logic             row_latch_q, row_latch_d;
  logic             oe_n_q, oe_n_d;
  logic             frame_done_q, frame_done_d;

  logic [CNT_W-1:0]  w_cnt_inc;
  logic [PROD_W-1:0] w_disp_last;
  logic              w_disp_end;
  logic              w_blank_end;

  // Lit when (c << 8) < D * (brightness + 1), D = BASE_TICKS << plane.
  // The c = 0 cycle is always lit because the right-hand side is never zero.
  function automatic logic lit_at(input logic [CNT_W-1:0] c,
                                  input logic [7:0]       b,
                                  input logic [PW-1:0]    p);
    logic [PROD_W-1:0] d_len;
    logic [PROD_W-1:0] lhs;
    logic [PROD_W-1:0] rhs;
    d_len = PROD_W'(BASE_TICKS) << p;
    lhs   = PROD_W'(c) << 8;
    rhs   = d_len * (PROD_W'(b) + PROD_W'(1));
    return lhs < rhs;
  endfunction

  assign w_cnt_inc   = cnt_q + CNT_W'(1);
  assign w_disp_last = (PROD_W'(BASE_TICKS) << shift_plane_q) - PROD_W'(1);
  assign w_disp_end  = (PROD_W'(cnt_q) == w_disp_last);
  assign w_blank_end = (cnt_q == CNT_W'(BLANK_TICKS - 1));

  // Next-state and registered-output computation; pulses default low, OE off.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bright_d      = bright_q;
    shift_start_d = 1'b0;
    shift_row_d   = shift_row_q;
    shift_plane_d = shift_plane_q;
    row_address_d = row_address_q;
    row_latch_d   = 1'b0;
    oe_n_d        = 1'b1;
    frame_done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d       = ST_SHIFT;
          shift_start_d = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (shift_done) begin
          state_d       = ST_BLANK;
          row_address_d = shift_row_q;
          cnt_d         = '0;
        end
      end

      ST_BLANK: begin
        if (w_blank_end) begin
          state_d     = ST_LATCH;
          row_latch_d = 1'b1;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end

      ST_LATCH: begin
        // Brightness is frozen here for the whole DISPLAY window.
        state_d  = ST_DISPLAY;
        cnt_d    = '0;
        bright_d = brightness;
        oe_n_d   = ~lit_at('0, brightness, shift_plane_q);
      end

      ST_DISPLAY: begin
        if (w_disp_end) begin
          if (shift_plane_q == PW'(BITPLANES - 1)) begin
            shift_plane_d = '0;
            if (shift_row_q == RW'(PIXEL_HALFHEIGHT - 1)) begin
              shift_row_d  = '0;
              frame_done_d = 1'b1;
            end else begin
              shift_row_d = shift_row_q + RW'(1);
            end
          end else begin
            shift_plane_d = shift_plane_q + PW'(1);
          end
          if (enable) begin
            state_d       = ST_SHIFT;
            shift_start_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d  = w_cnt_inc;
          oe_n_d = ~lit_at(w_cnt_inc, bright_q, shift_plane_q);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset blanks the panel immediately.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bright_q      <= '0;
      shift_start_q <= 1'b0;
      shift_row_q   <= '0;
      shift_plane_q <= '0;
      row_address_q <= '0;
      row_latch_q   <= 1'b0;
      oe_n_q        <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bright_q      <= bright_d;
      shift_start_q <= shift_start_d;
      shift_row_q   <= shift_row_d;
      shift_plane_q <= shift_plane_d;
      row_address_q <= row_address_d;
      row_latch_q   <= row_latch_d;
      oe_n_q        <= oe_n_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign shift_start = shift_start_q;
  assign shift_row   = shift_row_q;
  assign shift_plane = shift_plane_q;
  assign row_address = row_address_q;
  assign row_latch   = row_latch_q;
  assign oe_n        = oe_n_q;
  assign frame_done  = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hub75_scan_sequencer
// Description : Self-checking bench for hub75_scan_sequencer with a
//               position/brightness reference model and a random-latency
//               shifter responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_scan_sequencer;

  localparam int H     = 4;
  localparam int P     = 3;
  localparam int BT    = 4;
  localparam int BK    = 2;
  localparam int FRAME = H * P;

  logic       clk_in;
  logic       reset;
  logic       enable;
  logic [7:0] brightness;
  logic       shift_start;
  logic [1:0] shift_row;
  logic [1:0] shift_plane;
  logic       shift_done;
  logic [1:0] row_address;
  logic       row_latch;
  logic       oe_n;
  logic       frame_done;
  bit         clk_run;

  int checks;
  int errors;

  hub75_scan_sequencer #(
    .PIXEL_HALFHEIGHT(H),
    .BITPLANES       (P),
    .BASE_TICKS      (BT),
    .BLANK_TICKS     (BK)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .enable     (enable),
    .brightness (brightness),
    .shift_start(shift_start),
    .shift_row  (shift_row),
    .shift_plane(shift_plane),
    .shift_done (shift_done),
    .row_address(row_address),
    .row_latch  (row_latch),
    .oe_n       (oe_n),
    .frame_done (frame_done)
  );

  // Gated clock so the reset state can be observed with the clock idle.
  always #5 if (clk_run) clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".shift_start"}, 32'(shift_start), 32'(0));
    check({tag, ".shift_row"},   32'(shift_row),   32'(0));
    check({tag, ".shift_plane"}, 32'(shift_plane), 32'(0));
    check({tag, ".row_address"}, 32'(row_address), 32'(0));
    check({tag, ".row_latch"},   32'(row_latch),   32'(0));
    check({tag, ".oe_n"},        32'(oe_n),        32'(1));
    check({tag, ".frame_done"},  32'(frame_done),  32'(0));
  endtask

  // Number of lit cycles in a DISPLAY of length d: ceil(d*(b+1)/256), capped.
  function automatic int lit_cycles(input int d, input int b);
    int l;
    l = (d * (b + 1) + 255) / 256;
    if (l > d) l = d;
    return l;
  endfunction

  function automatic int bright_for(input int k);
    case (k)
      0, 1:    return 255;
      4:       return 127;
      7:       return 0;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // One full row/plane slot; k is the slot index since the last position reset.
  task automatic run_slot(input int k, input int lat, input int bright,
                          input bit en_after, input int abort_at);
    int  exp_row;
    int  exp_plane;
    int  d;
    int  lit;
    bit  found;
    exp_plane = k % P;
    exp_row   = (k / P) % H;
    d         = BT << exp_plane;
    lit       = lit_cycles(d, bright);
    found     = 1'b0;
    shift_done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (shift_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("shift_start_seen", 32'(found), 32'(1));
    if (!found) return;
    check("shift_row",   32'(shift_row),   32'(exp_row));
    check("shift_plane", 32'(shift_plane), 32'(exp_plane));
    check("shift_oe_n",  32'(oe_n),        32'(1));
    brightness = 8'(bright);
    for (int i = 0; i < lat; i++) begin
      step();
      check("shift_start_once", 32'(shift_start), 32'(0));
      check("wait_oe_n",        32'(oe_n),        32'(1));
    end
    shift_done = 1'b1;
    step();
    shift_done = 1'b0;
    check("row_address", 32'(row_address), 32'(exp_row));
    for (int i = 0; i < BK; i++) begin
      check("blank_oe_n",  32'(oe_n),      32'(1));
      check("blank_latch", 32'(row_latch), 32'(0));
      shift_done = ($urandom_range(0, 3) == 0);
      step();
    end
    check("latch_pulse", 32'(row_latch), 32'(1));
    check("latch_oe_n",  32'(oe_n),      32'(1));
    shift_done = ($urandom_range(0, 3) == 0);
    step();
    for (int c = 0; c < d; c++) begin
      check("disp_oe_n",       32'(oe_n),        32'((c < lit) ? 0 : 1));
      check("disp_latch",      32'(row_latch),   32'(0));
      check("disp_frame_done", 32'(frame_done),  32'(0));
      check("disp_shift",      32'(shift_start), 32'(0));
      check("disp_row_addr",   32'(row_address), 32'(exp_row));
      if (c == abort_at) begin
        #2 reset = 1'b1;
        #1;
        shift_done = 1'b0;
        check_reset_vals("reset_mid_display");
        return;
      end
      if (c == d / 2) enable = en_after;
      shift_done = ($urandom_range(0, 3) == 0);
      step();
    end
    shift_done = 1'b0;
    check("end_oe_n",        32'(oe_n),        32'(1));
    check("end_latch",       32'(row_latch),   32'(0));
    check("frame_done",      32'(frame_done),  32'(((k + 1) % FRAME) == 0));
    check("next_shift_start", 32'(shift_start), 32'(en_after));
  endtask

  initial begin
    clk_in     = 1'b0;
    clk_run    = 1'b0;
    reset      = 1'b1;
    enable     = 1'b0;
    brightness = 8'd0;
    shift_done = 1'b0;
    checks     = 0;
    errors     = 0;

    // Reset with the clock stopped.
    #3;
    check_reset_vals("reset_idle_clock");

    // Release with enable low: nothing may happen.
    clk_run = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      check("quiet_shift_start", 32'(shift_start), 32'(0));
      check("quiet_oe_n",        32'(oe_n),        32'(1));
    end

    // Enable from IDLE: shift_start in the very next cycle.
    enable = 1'b1;
    step();
    check("start_latency", 32'(shift_start), 32'(1));

    // One full frame plus the wrap into row 0 / plane 0.
    for (int k = 0; k <= FRAME; k++)
      run_slot(k, int'($urandom_range(0, 4)), bright_for(k), 1'b1, -1);

    // Drop enable mid-DISPLAY, idle, then resume at the next plane.
    run_slot(FRAME + 1, int'($urandom_range(0, 4)), bright_for(FRAME + 1), 1'b0, -1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_oe_n",        32'(oe_n),        32'(1));
      check("idle_shift_start", 32'(shift_start), 32'(0));
      check("idle_latch",       32'(row_latch),   32'(0));
    end
    enable = 1'b1;
    step();
    check("resume_latency", 32'(shift_start), 32'(1));
    run_slot(FRAME + 2, int'($urandom_range(0, 4)), bright_for(FRAME + 2), 1'b1, -1);

    // Reset while lit in DISPLAY, then restart from row 0 / plane 0.
    run_slot(FRAME + 3, int'($urandom_range(0, 4)), 255, 1'b1, 1);
    step();
    check_reset_vals("reset_hold");
    reset = 1'b0;
    run_slot(0, int'($urandom_range(0, 4)), bright_for(2), 1'b1, -1);
    run_slot(1, 0, bright_for(3), 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
